// File: rtl/pong_score_counter_if.sv
// Game-logic side of the pong score keeper: point levels and clear in,
// BCD digits and game status out.
interface pong_score_counter_if;
  logic       i_P1_Point;
  logic       i_P2_Point;
  logic       i_Clear;
  logic [3:0] o_P1_Tens;
  logic [3:0] o_P1_Ones;
  logic [3:0] o_P2_Tens;
  logic [3:0] o_P2_Ones;
  logic       o_Score_Strobe;
  logic       o_Game_Over;
  logic       o_Winner;

  modport master (
    output i_P1_Point, i_P2_Point, i_Clear,
    input  o_P1_Tens, o_P1_Ones, o_P2_Tens, o_P2_Ones,
    input  o_Score_Strobe, o_Game_Over, o_Winner
  );

  modport slave (
    input  i_P1_Point, i_P2_Point, i_Clear,
    output o_P1_Tens, o_P1_Ones, o_P2_Tens, o_P2_Ones,
    output o_Score_Strobe, o_Game_Over, o_Winner
  );
endinterface

// File: rtl/pong_score_counter.sv
// Two-player BCD score keeper: counts rising edges of the point levels,
// detects the winning score and latches game over until clear or reset.
module pong_score_counter #(
  parameter int WIN_SCORE = 11
) (
  input logic             i_Clk,
  input logic             i_Rst_n,
  pong_score_counter_if.slave bus
);

  generate
    if (WIN_SCORE < 1 || WIN_SCORE > 99) begin : g_bad_win_score
      $error("pong_score_counter: WIN_SCORE must be in 1..99");
    end
  endgenerate

  localparam logic [7:0] WIN_BCD = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};

  typedef enum logic {
    PLAY      = 1'b0,
    GAME_OVER = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic       p1_prev_q, p1_prev_d;
  logic       p2_prev_q, p2_prev_d;
  logic       p1_seen_low_q, p1_seen_low_d;
  logic       p2_seen_low_q, p2_seen_low_d;
  logic [7:0] p1_score_q, p1_score_d;
  logic [7:0] p2_score_q, p2_score_d;
  logic       strobe_q, strobe_d;
  logic       winner_q, winner_d;

  logic       p1_event, p2_event;
  logic [7:0] p1_inc, p2_inc;
  logic       p1_win, p2_win;

  // Scores stay at or below WIN_SCORE, so the tens digit never carries past 9.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) r = {4'(v[7:4] + 4'd1), 4'd0};
    else                r = {v[7:4], 4'(v[3:0] + 4'd1)};
    return r;
  endfunction

  // A level held high through reset must be seen low before it can score.
  always_comb begin
    p1_event      = bus.i_P1_Point & ~p1_prev_q & p1_seen_low_q;
    p2_event      = bus.i_P2_Point & ~p2_prev_q & p2_seen_low_q;
    p1_prev_d     = bus.i_P1_Point;
    p2_prev_d     = bus.i_P2_Point;
    p1_seen_low_d = p1_seen_low_q | ~bus.i_P1_Point;
    p2_seen_low_d = p2_seen_low_q | ~bus.i_P2_Point;
    p1_inc        = bcd_inc(p1_score_q);
    p2_inc        = bcd_inc(p2_score_q);
    p1_win        = p1_event && (p1_inc == WIN_BCD);
    p2_win        = p2_event && (p2_inc == WIN_BCD);
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) state_q <= PLAY;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.i_Clear)                              state_d = PLAY;
    else if (state_q == PLAY && (p1_win || p2_win)) state_d = GAME_OVER;
  end

  // Player 1 takes the win when both reach the winning score together.
  always_comb begin
    p1_score_d = p1_score_q;
    p2_score_d = p2_score_q;
    strobe_d   = 1'b0;
    winner_d   = winner_q;
    if (bus.i_Clear) begin
      p1_score_d = 8'd0;
      p2_score_d = 8'd0;
      winner_d   = 1'b0;
      strobe_d   = (p1_score_q != 8'd0) || (p2_score_q != 8'd0);
    end else if (state_q == PLAY) begin
      if (p1_event) p1_score_d = p1_inc;
      if (p2_event) p2_score_d = p2_inc;
      strobe_d = p1_event | p2_event;
      if (p1_win)      winner_d = 1'b0;
      else if (p2_win) winner_d = 1'b1;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      p1_prev_q     <= 1'b0;
      p2_prev_q     <= 1'b0;
      p1_seen_low_q <= 1'b0;
      p2_seen_low_q <= 1'b0;
      p1_score_q    <= 8'd0;
      p2_score_q    <= 8'd0;
      strobe_q      <= 1'b0;
      winner_q      <= 1'b0;
    end else begin
      p1_prev_q     <= p1_prev_d;
      p2_prev_q     <= p2_prev_d;
      p1_seen_low_q <= p1_seen_low_d;
      p2_seen_low_q <= p2_seen_low_d;
      p1_score_q    <= p1_score_d;
      p2_score_q    <= p2_score_d;
      strobe_q      <= strobe_d;
      winner_q      <= winner_d;
    end
  end

  always_comb begin
    bus.o_P1_Tens      = p1_score_q[7:4];
    bus.o_P1_Ones      = p1_score_q[3:0];
    bus.o_P2_Tens      = p2_score_q[7:4];
    bus.o_P2_Ones      = p2_score_q[3:0];
    bus.o_Score_Strobe = strobe_q;
    bus.o_Game_Over    = (state_q == GAME_OVER);
    bus.o_Winner       = winner_q;
  end

endmodule

// File: tb/tb_pong_score_counter.sv
// Bench for pong_score_counter: directed scenarios plus random point levels,
// all checked every cycle against an integer-score model of the game.
module tb_pong_score_counter;

  localparam int WIN = 11;

  logic clk;
  logic rst_n;
  int   tests_run = 0;
  int   tests_failed = 0;

  pong_score_counter_if bus_if ();

  pong_score_counter #(.WIN_SCORE(WIN)) dut (
    .i_Clk   (clk),
    .i_Rst_n (rst_n),
    .bus     (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: plain integer scores, split into digits only when compared.
  int m_s1, m_s2;
  bit m_go, m_win, m_strobe;
  bit m_prev1, m_prev2, m_seen1, m_seen2;
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    bit e1, e2;
    if (!rst_n) begin
      m_s1 = 0; m_s2 = 0; m_go = 0; m_win = 0; m_strobe = 0;
      m_prev1 = 0; m_prev2 = 0; m_seen1 = 0; m_seen2 = 0;
      m_valid = 1'b1;
    end else begin
      e1 = bus_if.i_P1_Point && !m_prev1 && m_seen1;
      e2 = bus_if.i_P2_Point && !m_prev2 && m_seen2;
      if (bus_if.i_Clear) begin
        m_strobe = (m_s1 != 0) || (m_s2 != 0);
        m_s1 = 0; m_s2 = 0; m_go = 0; m_win = 0;
      end else if (!m_go && (e1 || e2)) begin
        m_s1 += int'(e1);
        m_s2 += int'(e2);
        m_strobe = 1;
        if (m_s1 == WIN) begin m_go = 1; m_win = 0; end
        else if (m_s2 == WIN) begin m_go = 1; m_win = 1; end
      end else begin
        m_strobe = 0;
      end
      m_prev1 = bus_if.i_P1_Point;
      m_prev2 = bus_if.i_P2_Point;
      if (!bus_if.i_P1_Point) m_seen1 = 1;
      if (!bus_if.i_P2_Point) m_seen2 = 1;
    end
  end

  task automatic check_output(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      check_output("p1_tens", int'(bus_if.o_P1_Tens), m_s1 / 10);
      check_output("p1_ones", int'(bus_if.o_P1_Ones), m_s1 % 10);
      check_output("p2_tens", int'(bus_if.o_P2_Tens), m_s2 / 10);
      check_output("p2_ones", int'(bus_if.o_P2_Ones), m_s2 % 10);
      check_output("strobe", int'(bus_if.o_Score_Strobe), int'(m_strobe));
      check_output("game_over", int'(bus_if.o_Game_Over), int'(m_go));
      check_output("winner", int'(bus_if.o_Winner), int'(m_win));
    end
  end

  // Inputs change 1 time unit after the falling edge, one clock per call.
  task automatic apply_stimulus(input bit rn, input bit p1, input bit p2, input bit clr);
    rst_n = rn;
    bus_if.i_P1_Point = p1;
    bus_if.i_P2_Point = p2;
    bus_if.i_Clear = clr;
    @(negedge clk);
    #1;
  endtask

  task automatic pulse(input bit p1, input bit p2, input int n);
    for (int i = 0; i < n; i++) begin
      apply_stimulus(1, p1, p2, 0);
      apply_stimulus(1, 0, 0, 0);
    end
  endtask

  function automatic int p1_score();
    return int'(bus_if.o_P1_Tens) * 10 + int'(bus_if.o_P1_Ones);
  endfunction

  function automatic int p2_score();
    return int'(bus_if.o_P2_Tens) * 10 + int'(bus_if.o_P2_Ones);
  endfunction

  initial begin
    int strobes;
    bit r1, r2;
    rst_n = 1'b0;
    bus_if.i_P1_Point = 1'b0;
    bus_if.i_P2_Point = 1'b0;
    bus_if.i_Clear = 1'b0;

    // Point level held high through reset release never scores.
    apply_stimulus(0, 1, 0, 0);
    apply_stimulus(0, 1, 0, 0);
    check_output("reset_p1", p1_score(), 0);
    check_output("reset_go", int'(bus_if.o_Game_Over), 0);
    for (int i = 0; i < 3; i++) apply_stimulus(1, 1, 0, 0);
    check_output("held_through_reset", p1_score(), 0);
    apply_stimulus(1, 0, 0, 0);
    apply_stimulus(1, 1, 0, 0);
    check_output("first_edge_p1", p1_score(), 1);
    check_output("first_edge_strobe", int'(bus_if.o_Score_Strobe), 1);
    apply_stimulus(1, 0, 0, 0);
    check_output("strobe_one_cycle", int'(bus_if.o_Score_Strobe), 0);

    // BCD carry 09 -> 10 and one point for a held level.
    apply_stimulus(1, 0, 0, 1);
    check_output("clear_strobe", int'(bus_if.o_Score_Strobe), 1);
    pulse(1, 0, 9);
    check_output("p1_nine", p1_score(), 9);
    strobes = 0;
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1, 1, 0, 0);
      strobes += int'(bus_if.o_Score_Strobe);
    end
    check_output("carry_tens", int'(bus_if.o_P1_Tens), 1);
    check_output("carry_ones", int'(bus_if.o_P1_Ones), 0);
    check_output("held_one_strobe", strobes, 1);
    apply_stimulus(1, 0, 0, 0);

    // Player 2 wins; further points ignored.
    apply_stimulus(1, 0, 0, 1);
    pulse(0, 1, 10);
    check_output("p2_ten_not_over", int'(bus_if.o_Game_Over), 0);
    apply_stimulus(1, 0, 1, 0);
    check_output("p2_win_score", p2_score(), 11);
    check_output("p2_win_go", int'(bus_if.o_Game_Over), 1);
    check_output("p2_win_winner", int'(bus_if.o_Winner), 1);
    apply_stimulus(1, 0, 0, 0);
    pulse(1, 0, 1);
    check_output("go_ignores_p1", p1_score(), 0);
    check_output("go_holds_p2", p2_score(), 11);

    // Simultaneous win goes to player 1.
    apply_stimulus(1, 0, 0, 1);
    pulse(1, 1, 10);
    apply_stimulus(1, 1, 1, 0);
    check_output("tie_p1", p1_score(), 11);
    check_output("tie_p2", p2_score(), 11);
    check_output("tie_go", int'(bus_if.o_Game_Over), 1);
    check_output("tie_winner", int'(bus_if.o_Winner), 0);
    apply_stimulus(1, 0, 0, 0);

    // Clear beats a same-cycle point edge.
    apply_stimulus(1, 1, 0, 1);
    check_output("clear_p1", p1_score(), 0);
    check_output("clear_go", int'(bus_if.o_Game_Over), 0);
    check_output("clear_go_strobe", int'(bus_if.o_Score_Strobe), 1);
    apply_stimulus(1, 0, 0, 0);
    apply_stimulus(1, 1, 0, 0);
    check_output("after_clear_p1", p1_score(), 1);
    apply_stimulus(1, 0, 0, 0);

    // Mid-game reset with a point edge.
    apply_stimulus(1, 0, 0, 1);
    pulse(1, 0, 7);
    pulse(0, 1, 5);
    check_output("mid_p1", p1_score(), 7);
    check_output("mid_p2", p2_score(), 5);
    apply_stimulus(0, 1, 0, 0);
    check_output("rst_mid_p1", p1_score(), 0);
    check_output("rst_mid_p2", p2_score(), 0);
    check_output("rst_mid_strobe", int'(bus_if.o_Score_Strobe), 0);
    apply_stimulus(1, 0, 0, 0);

    // Random point levels with occasional clear and reset.
    r1 = 0; r2 = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 35) r1 = ~r1;
      if ($urandom_range(0, 99) < 35) r2 = ~r2;
      apply_stimulus(($urandom_range(0, 399) != 0), r1, r2, ($urandom_range(0, 149) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
